fetch_unit: RTL and testbench

Instruction fetch front end for the pipelined RV32I core. Owns the program counter and issues one outstanding request at a time to a variable-latency instruction memory. Buffers returned instructions in a small queue that feeds decode through a valid/ready handshake. Accepts PC redirects from branch/jump resolution and discards all wrong-path fetches.

---
 rtl/core_pkg.sv | 17 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I front end: fetch FSM states, reset PC, NOP and queue entry.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, inst} entries with a same-cycle flush.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       valid,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // Anything popped this cycle is already consumed; the rest is wrong-path.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one memory request in flight,
// buffers returned words for decode and squashes wrong-path fetches on redirect.
module fetch_unit
    import core_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_pc_plus_4
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]         CNT_ONE  = 1;
    localparam logic [CW-1:0]         CNT_FULL = CW'(QUEUE_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = 4;

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] pending_pc;
    logic [DATA_WIDTH-1:0] target_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_post;
    logic                  push;
    logic                  pop;
    logic                  q_valid;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    assign target_pc  = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign pop        = q_valid && if_ready;
    assign push       = (state == S_REQ) && imem_ack && !redirect_valid;
    assign push_entry = '{pc: fetch_pc, inst: imem_rdata};
    // Occupancy after an accepted response this cycle, used to decide whether to keep fetching.
    assign count_post = count + CNT_ONE - {{(CW-1){1'b0}}, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= target_pc;
                        state    <= S_REQ;
                    end else if (count < CNT_FULL) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack && redirect_valid) begin
                        fetch_pc <= target_pc;
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                        if (count_post >= CNT_FULL) state <= S_IDLE;
                    end else if (redirect_valid) begin
                        // Request must stay stable until acked; remember where to go afterwards.
                        pending_pc <= target_pc;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        fetch_pc <= redirect_valid ? target_pc : pending_pc;
                        state    <= S_REQ;
                    end else if (redirect_valid) begin
                        pending_pc <= target_pc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_req  = (state != S_IDLE);
    assign imem_addr = fetch_pc;

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (redirect_valid),
        .valid (q_valid),
        .head  (head),
        .count (count)
    );

    assign if_valid     = q_valid;
    assign if_inst      = head.inst;
    assign if_pc        = head.pc;
    assign if_pc_plus_4 = head.pc + PC_STEP;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model, directed scenarios and random
// traffic, with a decoupled scoreboard predicting the delivered instruction stream.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;

    int total = 0;
    int bad = 0;
    int delivered = 0;
    int lat_lo = 0;
    int lat_hi = 0;
    int lat_cur;
    int wait_cnt;
    logic [31:0] redir_q[$];

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory: ack after lat_cur waiting cycles (0 = same cycle), new latency per request.
    assign imem_rdata = inst_of(imem_addr);
    assign imem_ack   = imem_req && (wait_cnt >= lat_cur);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
            lat_cur  <= lat_lo;
        end else if (imem_ack) begin
            wait_cnt <= 0;
            lat_cur  <= $urandom_range(lat_hi, lat_lo);
        end else if (imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: decode must see a sequential stream that restarts at each redirect target.
    initial begin
        logic [31:0] exp_pc;
        logic        prev_pend;
        logic [31:0] prev_addr;
        exp_pc = RPC;
        prev_pend = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc = RPC;
                redir_q.delete();
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                prev_pend = imem_req && !imem_ack;
                prev_addr = imem_addr;
                if (if_valid && if_ready) begin
                    chk("deq_pc", if_pc, exp_pc);
                    chk("deq_inst", if_inst, inst_of(exp_pc));
                    chk("deq_pc4", if_pc_plus_4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
                if (redirect_valid) begin
                    if (redir_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL redir_q actual=empty expected=target");
                    end else begin
                        exp_pc = redir_q.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        redir_q.push_back(t & 32'hFFFF_FFFC);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_addr(input logic [31:0] a, input string name);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk(name, imem_addr, a);
    endtask

    initial begin
        int n;
        int d0;
        // Reset values and sequential zero-wait fetch.
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc_plus_4, 32'd4);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k < 3) begin
                chk("seq_req", 32'(imem_req), 32'd1);
                chk("seq_addr", imem_addr, 32'(4 * k));
            end
            if (k >= 1) begin
                chk("seq_valid", 32'(if_valid), 32'd1);
                chk("seq_if_pc", if_pc, 32'(4 * (k - 1)));
                chk("seq_if_pc4", if_pc_plus_4, 32'(4 * k));
            end
        end

        // Back-pressure: queue fills, fetch stops, resumes from the registered count.
        if_ready = 1'b0;
        do_reset();
        repeat (6) step();
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_valid", 32'(if_valid), 32'd1);
        if_ready = 1'b1;
        step();
        step();
        chk("resume_req", 32'(imem_req), 32'd1);
        if_ready = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_full_valid", 32'(if_valid), 32'd0);
        chk("arst_full_req", 32'(imem_req), 32'd0);
        if_ready = 1'b1;

        // Redirect while the 0x8 request is outstanding on a 3-cycle memory.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        step();
        wait_addr(32'h8, "drain_wait8");
        step();
        redir(32'h100);
        step();
        redirect_valid = 1'b0;
        chk("drain_valid", 32'(if_valid), 32'd0);
        chk("drain_stale_addr", imem_addr, 32'h8);
        n = 0;
        while (!imem_ack && n < 20) begin step(); n++; end
        step();
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_new_addr", imem_addr, 32'h100);
        n = 0;
        while (!if_valid && n < 20) begin step(); n++; end
        chk("drain_if_pc", if_pc, 32'h100);

        // Redirect coinciding with the ack for 0xC.
        lat_lo = 0; lat_hi = 0;
        do_reset();
        step();
        wait_addr(32'hC, "same_waitC");
        redir(32'h203);
        step();
        redirect_valid = 1'b0;
        chk("same_addr", imem_addr, 32'h200);
        chk("same_req", 32'(imem_req), 32'd1);
        chk("same_valid", 32'(if_valid), 32'd0);
        repeat (4) step();

        // Reset asserted asynchronously while draining.
        lat_lo = 5; lat_hi = 5;
        do_reset();
        step();
        step();
        redir(32'h40);
        step();
        redirect_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_drain_valid", 32'(if_valid), 32'd0);
        chk("arst_drain_req", 32'(imem_req), 32'd0);
        chk("arst_drain_addr", imem_addr, RPC);
        lat_lo = 0; lat_hi = 0;
        do_reset();
        step();
        chk("restart_addr", imem_addr, RPC);
        chk("restart_req", 32'(imem_req), 32'd1);

        // PC wrap at the top of the address space.
        redir(32'hFFFF_FFF8);
        step();
        redirect_valid = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr2", imem_addr, 32'h0000_0000);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc4", if_pc_plus_4, 32'h0000_0000);

        // Random traffic: stalls, latencies 0..3, sporadic redirects.
        lat_lo = 0; lat_hi = 3;
        do_reset();
        d0 = delivered;
        for (int c = 0; c < 2500; c++) begin
            step();
            redirect_valid = 1'b0;
            if_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 3) == 0) redir(32'hFFFF_FFE0 | ($urandom & 32'h1F));
                else redir($urandom & 32'h0000_FFFF);
            end
        end
        step();
        redirect_valid = 1'b0;
        chk("rand_progress", 32'(delivered - d0 >= 200), 32'd1);

        if_ready = 1'b1;
        lat_lo = 0; lat_hi = 0;
        d0 = delivered;
        repeat (20) step();
        chk("final_progress", 32'(delivered - d0 >= 10), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
